// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the scalar/vector RAM arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, BURST, DRAIN)
//   - MEM_ARB_AW / MEM_ARB_DW / MEM_ARB_VLEN : default address width,
//     data width and lanes per vector burst
//   - beat_bits() : width of the beat/lane index for a given VLEN
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_AW   = 32;
    localparam int unsigned MEM_ARB_DW   = 32;
    localparam int unsigned MEM_ARB_VLEN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    function automatic int unsigned beat_bits(input int unsigned vlen);
        return (vlen > 1) ? $clog2(vlen) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_vbuf.sv
// mem_arb_vbuf
// VLEN x DW lane register with per-lane write enable and asynchronous clear.
// Holds either the latched vector write data or the assembled read lanes.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear of all lanes
//   we_i    : per-lane write enable, bit i writes lane i
//   wd_i    : write data, lane 0 in the LSBs
//   q_o     : current lane contents, lane 0 in the LSBs
module mem_arb_vbuf #(
    parameter int unsigned DW   = 32,
    parameter int unsigned VLEN = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [VLEN-1:0]      we_i,
    input  logic [VLEN*DW-1:0]   wd_i,
    output logic [VLEN*DW-1:0]   q_o
);

    logic [VLEN*DW-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        for (int unsigned i = 0; i < VLEN; i++) begin
            if (we_i[i]) begin
                data_d[i*DW +: DW] = wd_i[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter sharing a single-port data RAM between the scalar
// load/store port and the vector load/store unit. Scalar accesses are
// granted and performed in one cycle; vector bursts issue VLEN consecutive
// word beats, then a DRAIN cycle, then a registered V_DONE pulse.
// Ports:
//   CLK, RST            : clock / asynchronous active-low reset
//   S_REQ/S_WE/S_ADDR/S_WD -> S_GNT, S_RVALID, S_RD : scalar port
//   V_REQ/V_WE/V_ADDR/V_WD -> V_GNT, V_DONE, V_RD   : vector port
//   MEM_A/MEM_WD/MEM_WE, MEM_RD                     : RAM side (1-cycle read)
//   STALL_S/STALL_V     : saturating wait counters, present only when
//                         MEM_ARB_STALL_CNT_EN is defined
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW   = MEM_ARB_AW,
    parameter int unsigned DW   = MEM_ARB_DW,
    parameter int unsigned VLEN = MEM_ARB_VLEN
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 S_REQ,
    input  logic                 S_WE,
    input  logic [AW-1:0]        S_ADDR,
    input  logic [DW-1:0]        S_WD,
    output logic                 S_GNT,
    output logic                 S_RVALID,
    output logic [DW-1:0]        S_RD,
    input  logic                 V_REQ,
    input  logic                 V_WE,
    input  logic [AW-1:0]        V_ADDR,
    input  logic [VLEN*DW-1:0]   V_WD,
    output logic                 V_GNT,
    output logic                 V_DONE,
    output logic [VLEN*DW-1:0]   V_RD,
    output logic [AW-1:0]        MEM_A,
    output logic [DW-1:0]        MEM_WD,
    output logic                 MEM_WE,
    input  logic [DW-1:0]        MEM_RD
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]          STALL_S,
    output logic [15:0]          STALL_V
`endif
);

    localparam int unsigned BW = beat_bits(VLEN);

    arb_state_e      state_q, state_d;
    logic            last_v_q, last_v_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [AW-1:0]   base_q, base_d;
    logic            we_q, we_d;
    logic            s_rvalid_q, s_rvalid_d;
    logic            v_done_q, v_done_d;
    logic            cap_q, cap_d;
    logic [BW-1:0]   cap_lane_q, cap_lane_d;

    logic            idle_ok;
    logic            s_win;
    logic            v_win;
    logic [VLEN-1:0]    wbuf_we;
    logic [VLEN-1:0]    rbuf_we;
    logic [VLEN*DW-1:0] wbuf_q;

    // Grants are combinational and gated by RST so that every output is
    // forced low while reset is asserted, even with requests held high.
    assign idle_ok = RST && (state_q == IDLE);
    assign s_win   = idle_ok && S_REQ && (!V_REQ || last_v_q);
    assign v_win   = idle_ok && V_REQ && !s_win;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            last_v_q   <= 1'b1;
            beat_q     <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            s_rvalid_q <= 1'b0;
            v_done_q   <= 1'b0;
            cap_q      <= 1'b0;
            cap_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            last_v_q   <= last_v_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            we_q       <= we_d;
            s_rvalid_q <= s_rvalid_d;
            v_done_q   <= v_done_d;
            cap_q      <= cap_d;
            cap_lane_q <= cap_lane_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        last_v_d   = last_v_q;
        beat_d     = beat_q;
        base_d     = base_q;
        we_d       = we_q;
        s_rvalid_d = s_win && !S_WE;
        v_done_d   = (state_q == DRAIN);
        cap_d      = 1'b0;
        cap_lane_d = cap_lane_q;

        unique case (state_q)
            IDLE: begin
                if (s_win) begin
                    last_v_d = 1'b0;
                end else if (v_win) begin
                    last_v_d   = 1'b1;
                    base_d     = V_ADDR;
                    we_d       = V_WE;
                    beat_d     = BW'(1);
                    state_d    = BURST;
                    cap_d      = !V_WE;
                    cap_lane_d = '0;
                end
            end
            BURST: begin
                // The lane issued this cycle is captured from MEM_RD next cycle.
                cap_d      = !we_q;
                cap_lane_d = beat_q;
                if (beat_q == BW'(VLEN - 1)) begin
                    beat_d  = '0;
                    state_d = DRAIN;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        S_GNT  = 1'b0;
        V_GNT  = 1'b0;
        MEM_A  = '0;
        MEM_WD = '0;
        MEM_WE = 1'b0;

        if (s_win) begin
            S_GNT  = 1'b1;
            MEM_A  = S_ADDR;
            MEM_WD = S_WD;
            MEM_WE = S_WE;
        end else if (v_win) begin
            // Beat 0 goes straight from the request; later beats use the latched copy.
            V_GNT  = 1'b1;
            MEM_A  = V_ADDR;
            MEM_WD = V_WD[DW-1:0];
            MEM_WE = V_WE;
        end else if (RST && (state_q == BURST)) begin
            MEM_A  = base_q + AW'(beat_q);
            MEM_WE = we_q;
            if (we_q) begin
                for (int unsigned i = 0; i < VLEN; i++) begin
                    if (beat_q == BW'(i)) begin
                        MEM_WD = wbuf_q[i*DW +: DW];
                    end
                end
            end
        end
    end

    always_comb begin
        wbuf_we = {VLEN{v_win && V_WE}};
        rbuf_we = '0;
        for (int unsigned i = 0; i < VLEN; i++) begin
            rbuf_we[i] = cap_q && (cap_lane_q == BW'(i));
        end
    end

    mem_arb_vbuf #(
        .DW   (DW),
        .VLEN (VLEN)
    ) u_wbuf (
        .clk_i  (CLK),
        .rst_ni (RST),
        .we_i   (wbuf_we),
        .wd_i   (V_WD),
        .q_o    (wbuf_q)
    );

    mem_arb_vbuf #(
        .DW   (DW),
        .VLEN (VLEN)
    ) u_rbuf (
        .clk_i  (CLK),
        .rst_ni (RST),
        .we_i   (rbuf_we),
        .wd_i   ({VLEN{MEM_RD}}),
        .q_o    (V_RD)
    );

    assign S_RVALID = s_rvalid_q;
    assign S_RD     = MEM_RD;
    assign V_DONE   = v_done_q;

`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] stall_s_q, stall_s_d;
    logic [15:0] stall_v_q, stall_v_d;

    always_comb begin
        stall_s_d = stall_s_q;
        stall_v_d = stall_v_q;
        if (S_REQ && !S_GNT && (stall_s_q != 16'hFFFF)) begin
            stall_s_d = stall_s_q + 16'd1;
        end
        if (V_REQ && !V_GNT && (stall_v_q != 16'hFFFF)) begin
            stall_v_d = stall_v_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_s_q <= '0;
            stall_v_q <= '0;
        end else begin
            stall_s_q <= stall_s_d;
            stall_v_q <= stall_v_d;
        end
    end

    assign STALL_S = stall_s_q;
    assign STALL_V = stall_v_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned VLEN = 4;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 S_REQ, S_WE;
    logic [AW-1:0]        S_ADDR;
    logic [DW-1:0]        S_WD;
    logic                 S_GNT, S_RVALID;
    logic [DW-1:0]        S_RD;
    logic                 V_REQ, V_WE;
    logic [AW-1:0]        V_ADDR;
    logic [VLEN*DW-1:0]   V_WD;
    logic                 V_GNT, V_DONE;
    logic [VLEN*DW-1:0]   V_RD;
    logic [AW-1:0]        MEM_A;
    logic [DW-1:0]        MEM_WD;
    logic                 MEM_WE;
    logic [DW-1:0]        MEM_RD = '0;
`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0]          STALL_S, STALL_V;
`endif

    int nvec = 0;
    int nerr = 0;

    logic [VLEN*DW-1:0] lanes4321;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .AW   (AW),
        .DW   (DW),
        .VLEN (VLEN)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .S_REQ    (S_REQ),
        .S_WE     (S_WE),
        .S_ADDR   (S_ADDR),
        .S_WD     (S_WD),
        .S_GNT    (S_GNT),
        .S_RVALID (S_RVALID),
        .S_RD     (S_RD),
        .V_REQ    (V_REQ),
        .V_WE     (V_WE),
        .V_ADDR   (V_ADDR),
        .V_WD     (V_WD),
        .V_GNT    (V_GNT),
        .V_DONE   (V_DONE),
        .V_RD     (V_RD),
        .MEM_A    (MEM_A),
        .MEM_WD   (MEM_WD),
        .MEM_WE   (MEM_WE),
        .MEM_RD   (MEM_RD)
`ifdef MEM_ARB_STALL_CNT_EN
        ,
        .STALL_S  (STALL_S),
        .STALL_V  (STALL_V)
`endif
    );

    // Single-port RAM with one-cycle read latency (read-before-write).
    logic [DW-1:0] ram [logic [AW-1:0]];
    always @(posedge CLK) begin
        if (ram.exists(MEM_A)) MEM_RD <= ram[MEM_A];
        else                   MEM_RD <= '0;
        if (MEM_WE) ram[MEM_A] = MEM_WD;
    end

    task automatic idle_inputs();
        S_REQ = 1'b0; S_WE = 1'b0; S_ADDR = '0; S_WD = '0;
        V_REQ = 1'b0; V_WE = 1'b0; V_ADDR = '0; V_WD = '0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        S_REQ = 1'b1; S_WE = 1'b1; S_ADDR = 32'h55; S_WD = 32'h1234;
        V_REQ = 1'b1; V_WE = 1'b1; V_ADDR = 32'h7; V_WD = '1;
        #1;
        nvec++; if (S_GNT !== 1'b0) begin nerr++; $display("FAIL rst_s_gnt: got %b want 0", S_GNT); end
        nvec++; if (V_GNT !== 1'b0) begin nerr++; $display("FAIL rst_v_gnt: got %b want 0", V_GNT); end
        nvec++; if (MEM_WE !== 1'b0) begin nerr++; $display("FAIL rst_mem_we: got %b want 0", MEM_WE); end
        nvec++; if (MEM_A !== 32'h0) begin nerr++; $display("FAIL rst_mem_a: got %h want 0", MEM_A); end
        nvec++; if (MEM_WD !== 32'h0) begin nerr++; $display("FAIL rst_mem_wd: got %h want 0", MEM_WD); end
        nvec++; if (V_DONE !== 1'b0) begin nerr++; $display("FAIL rst_v_done: got %b want 0", V_DONE); end
        nvec++; if (S_RVALID !== 1'b0) begin nerr++; $display("FAIL rst_s_rvalid: got %b want 0", S_RVALID); end
        nvec++; if (V_RD !== '0) begin nerr++; $display("FAIL rst_v_rd: got %h want 0", V_RD); end
`ifdef MEM_ARB_STALL_CNT_EN
        nvec++; if (STALL_S !== 16'h0) begin nerr++; $display("FAIL rst_stall_s: got %h want 0", STALL_S); end
`endif
        @(negedge CLK); idle_inputs();
        @(negedge CLK); RST = 1'b1;
    endtask

    task automatic test_scalar();
        @(negedge CLK);
        S_REQ = 1'b1; S_WE = 1'b1; S_ADDR = 32'd10; S_WD = 32'hDEAD_BEEF;
        #1;
        nvec++; if (S_GNT !== 1'b1) begin nerr++; $display("FAIL sc_wr_gnt: got %b want 1", S_GNT); end
        nvec++; if (MEM_A !== 32'd10) begin nerr++; $display("FAIL sc_wr_a: got %h want a", MEM_A); end
        nvec++; if (MEM_WE !== 1'b1) begin nerr++; $display("FAIL sc_wr_we: got %b want 1", MEM_WE); end
        nvec++; if (MEM_WD !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL sc_wr_wd: got %h want deadbeef", MEM_WD); end
        @(negedge CLK);
        S_WE = 1'b0; S_WD = '0;
        #1;
        nvec++; if (S_GNT !== 1'b1) begin nerr++; $display("FAIL sc_rd_gnt: got %b want 1", S_GNT); end
        nvec++; if (MEM_WE !== 1'b0) begin nerr++; $display("FAIL sc_rd_we: got %b want 0", MEM_WE); end
        nvec++; if (S_RVALID !== 1'b0) begin nerr++; $display("FAIL sc_wr_norvalid: got %b want 0", S_RVALID); end
        @(negedge CLK);
        idle_inputs();
        #1;
        nvec++; if (S_RVALID !== 1'b1) begin nerr++; $display("FAIL sc_rvalid: got %b want 1", S_RVALID); end
        nvec++; if (S_RD !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL sc_rd: got %h want deadbeef", S_RD); end
        @(negedge CLK); #1;
        nvec++; if (S_RVALID !== 1'b0) begin nerr++; $display("FAIL sc_rvalid_drop: got %b want 0", S_RVALID); end
    endtask

    task automatic test_vector();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge CLK);
        V_REQ = 1'b1; V_WE = 1'b1; V_ADDR = 32'd100; V_WD = lanes4321;
        #1;
        nvec++; if (V_GNT !== 1'b1) begin nerr++; $display("FAIL vw_gnt: got %b want 1", V_GNT); end
        nvec++; if (MEM_A !== 32'd100) begin nerr++; $display("FAIL vw_a0: got %h want 64", MEM_A); end
        nvec++; if (MEM_WD !== 32'd1) begin nerr++; $display("FAIL vw_wd0: got %h want 1", MEM_WD); end
        nvec++; if (MEM_WE !== 1'b1) begin nerr++; $display("FAIL vw_we0: got %b want 1", MEM_WE); end
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK);
            V_REQ = 1'b0; V_WD = '0;
            #1;
            ea = 32'd100 + 32'(i);
            ed = 32'(i + 1);
            nvec++; if (MEM_A !== ea) begin nerr++; $display("FAIL vw_a%0d: got %h want %h", i, MEM_A, ea); end
            nvec++; if (MEM_WD !== ed) begin nerr++; $display("FAIL vw_wd%0d: got %h want %h", i, MEM_WD, ed); end
            nvec++; if (MEM_WE !== 1'b1) begin nerr++; $display("FAIL vw_we%0d: got %b want 1", i, MEM_WE); end
            nvec++; if (V_GNT !== 1'b0) begin nerr++; $display("FAIL vw_gnt%0d: got %b want 0", i, V_GNT); end
        end
        @(negedge CLK); #1;
        nvec++; if (MEM_WE !== 1'b0) begin nerr++; $display("FAIL vw_drain_we: got %b want 0", MEM_WE); end
        nvec++; if (V_DONE !== 1'b0) begin nerr++; $display("FAIL vw_drain_done: got %b want 0", V_DONE); end
        // grant+5: V_DONE, and the RAM is free for a new grant in the same cycle
        @(negedge CLK);
        V_REQ = 1'b1; V_WE = 1'b0; V_ADDR = 32'd100;
        #1;
        nvec++; if (V_DONE !== 1'b1) begin nerr++; $display("FAIL vw_done: got %b want 1", V_DONE); end
        nvec++; if (V_GNT !== 1'b1) begin nerr++; $display("FAIL vr_gnt: got %b want 1", V_GNT); end
        nvec++; if (MEM_A !== 32'd100) begin nerr++; $display("FAIL vr_a0: got %h want 64", MEM_A); end
        nvec++; if (MEM_WE !== 1'b0) begin nerr++; $display("FAIL vr_we0: got %b want 0", MEM_WE); end
        nvec++; if (V_RD !== '0) begin nerr++; $display("FAIL vw_no_rd: got %h want 0", V_RD); end
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK);
            V_REQ = 1'b0;
            #1;
            ea = 32'd100 + 32'(i);
            nvec++; if (MEM_A !== ea) begin nerr++; $display("FAIL vr_a%0d: got %h want %h", i, MEM_A, ea); end
            nvec++; if (MEM_WE !== 1'b0) begin nerr++; $display("FAIL vr_we%0d: got %b want 0", i, MEM_WE); end
        end
        @(negedge CLK); #1;
        nvec++; if (V_DONE !== 1'b0) begin nerr++; $display("FAIL vr_drain_done: got %b want 0", V_DONE); end
        @(negedge CLK); #1;
        nvec++; if (V_DONE !== 1'b1) begin nerr++; $display("FAIL vr_done: got %b want 1", V_DONE); end
        nvec++; if (V_RD !== lanes4321) begin nerr++; $display("FAIL vr_lanes: got %h want %h", V_RD, lanes4321); end
        @(negedge CLK); #1;
        nvec++; if (V_DONE !== 1'b0) begin nerr++; $display("FAIL vr_done_pulse: got %b want 0", V_DONE); end
        nvec++; if (V_RD !== lanes4321) begin nerr++; $display("FAIL vr_hold: got %h want %h", V_RD, lanes4321); end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        V_REQ = 1'b1; V_WE = 1'b1; V_ADDR = 32'd200; V_WD = lanes4321;
        #1;
        nvec++; if (V_GNT !== 1'b1) begin nerr++; $display("FAIL rm_gnt: got %b want 1", V_GNT); end
        @(negedge CLK);
        idle_inputs();
        @(negedge CLK); #1;
        nvec++; if (MEM_A !== 32'd202) begin nerr++; $display("FAIL rm_beat2_a: got %h want ca", MEM_A); end
        nvec++; if (MEM_WE !== 1'b1) begin nerr++; $display("FAIL rm_beat2_we: got %b want 1", MEM_WE); end
        RST = 1'b0;
        #1;
        nvec++; if (MEM_WE !== 1'b0) begin nerr++; $display("FAIL rm_we_async: got %b want 0", MEM_WE); end
        nvec++; if (MEM_A !== 32'h0) begin nerr++; $display("FAIL rm_a_async: got %h want 0", MEM_A); end
        nvec++; if (V_RD !== '0) begin nerr++; $display("FAIL rm_vrd_clr: got %h want 0", V_RD); end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); #1;
            nvec++; if (V_DONE !== 1'b0) begin nerr++; $display("FAIL rm_no_done%0d: got %b want 0", i, V_DONE); end
        end
        @(negedge CLK);
        S_REQ = 1'b1; V_REQ = 1'b1; S_ADDR = 32'd5; V_ADDR = 32'd300;
        #1;
        nvec++; if (S_GNT !== 1'b1) begin nerr++; $display("FAIL rm_tie_s: got %b want 1", S_GNT); end
        nvec++; if (V_GNT !== 1'b0) begin nerr++; $display("FAIL rm_tie_v: got %b want 0", V_GNT); end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_round_robin();
        @(negedge CLK); RST = 1'b0; idle_inputs();
        @(negedge CLK); RST = 1'b1;
        // c0: tie out of reset
        @(negedge CLK);
        S_REQ = 1'b1; V_REQ = 1'b1; S_ADDR = 32'd20; V_ADDR = 32'd400;
        #1;
        nvec++; if (S_GNT !== 1'b1) begin nerr++; $display("FAIL rr_c0_s: got %b want 1", S_GNT); end
        nvec++; if (V_GNT !== 1'b0) begin nerr++; $display("FAIL rr_c0_v: got %b want 0", V_GNT); end
        // c1: vector alone (grant t)
        @(negedge CLK);
        S_REQ = 1'b0;
        #1;
        nvec++; if (V_GNT !== 1'b1) begin nerr++; $display("FAIL rr_c1_v: got %b want 1", V_GNT); end
        // c2..c5: both waiting during burst and drain
        for (int i = 2; i < 6; i++) begin
            @(negedge CLK);
            S_REQ = 1'b1; V_REQ = 1'b1;
            #1;
            nvec++; if (S_GNT !== 1'b0) begin nerr++; $display("FAIL rr_c%0d_s: got %b want 0", i, S_GNT); end
            nvec++; if (V_GNT !== 1'b0) begin nerr++; $display("FAIL rr_c%0d_v: got %b want 0", i, V_GNT); end
        end
        // c6 = t+5: tie, vector granted last -> scalar
        @(negedge CLK); #1;
        nvec++; if (S_GNT !== 1'b1) begin nerr++; $display("FAIL rr_c6_s: got %b want 1", S_GNT); end
        nvec++; if (V_GNT !== 1'b0) begin nerr++; $display("FAIL rr_c6_v: got %b want 0", V_GNT); end
`ifdef MEM_ARB_STALL_CNT_EN
        nvec++; if (STALL_S !== 16'd4) begin nerr++; $display("FAIL rr_stall_s: got %0d want 4", STALL_S); end
        nvec++; if (STALL_V !== 16'd5) begin nerr++; $display("FAIL rr_stall_v: got %0d want 5", STALL_V); end
`endif
        // c7: new scalar request ties again, scalar granted last -> vector
        @(negedge CLK);
        S_ADDR = 32'd21;
        #1;
        nvec++; if (V_GNT !== 1'b1) begin nerr++; $display("FAIL rr_c7_v: got %b want 1", V_GNT); end
        nvec++; if (S_GNT !== 1'b0) begin nerr++; $display("FAIL rr_c7_s: got %b want 0", S_GNT); end
        @(negedge CLK);
        idle_inputs();
        repeat (6) @(negedge CLK);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF;
        exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
        @(negedge CLK);
        V_REQ = 1'b1; V_WE = 1'b0; V_ADDR = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge CLK);
                V_REQ = 1'b0;
            end
            #1;
            nvec++; if (MEM_A !== exp_a[i]) begin nerr++; $display("FAIL wrap_a%0d: got %h want %h", i, MEM_A, exp_a[i]); end
        end
        @(negedge CLK);
        @(negedge CLK); #1;
        nvec++; if (V_DONE !== 1'b1) begin nerr++; $display("FAIL wrap_done: got %b want 1", V_DONE); end
    endtask

    initial begin
        lanes4321 = {32'd4, 32'd3, 32'd2, 32'd1};
        test_reset();
        test_scalar();
        test_vector();
        test_reset_mid();
        test_round_robin();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port data RAM between the scalar core load/store port and the vector load/store unit. It sits between both requesters and the memory-mapped address-control stage that fronts the RAM and the I/O registers. The block grants single-cycle scalar accesses, sequences multi-beat vector bursts, and assembles vector read lanes. Arbitration is round-robin.

## Interface
- AW, 32, address width
- DW, 32, data word width
- VLEN, 4, lanes per vector burst (≥2)
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- S_REQ  input  1  scalar request; held until S_GNT
- S_WE  input  1  scalar write (1) / read (0)
- S_ADDR  input  AW  scalar word address
- S_WD  input  DW  scalar write data
- S_GNT  output  1  scalar access performed this cycle
- S_RVALID  output  1  S_RD valid
- S_RD  output  DW  scalar read data
- V_REQ  input  1  vector request; held until V_GNT
- V_WE  input  1  vector write / read
- V_ADDR  input  AW  vector base word address
- V_WD  input  VLEN*DW  vector write data, lane 0 in LSBs
- V_GNT  output  1  burst accepted; beat 0 issued this cycle
- V_DONE  output  1  one-cycle burst completion pulse
- V_RD  output  VLEN*DW  assembled read lanes
- MEM_A  output  AW  RAM address
- MEM_WD  output  DW  RAM write data
- MEM_WE  output  1  RAM write enable
- MEM_RD  input  DW  RAM read data, valid one cycle after MEM_A
- STALL_S, STALL_V  output  16  stall counters (only with macro, see Configuration)

## Operation
- FSM states: IDLE, BURST, DRAIN. Reset state IDLE.
- IDLE: requests are evaluated combinationally. A single requester wins. If both request, the winner is the one not granted last (LAST_V flag). LAST_V resets to 1, so scalar wins the first tie. LAST_V updates on every grant.
- Scalar grant (IDLE only):
  - S_GNT=1; MEM_A=S_ADDR, MEM_WD=S_WD, MEM_WE=S_WE.
  - State stays IDLE.
  - For a read, S_RVALID=1 the next cycle; S_RD passes MEM_RD through.
- Vector grant:
  - V_GNT=1. Latch base address, V_WE and V_WD.
  - Beat 0 is issued in the grant cycle; go to BURST with beat counter=1.
- BURST: issue beat i with MEM_A = base+i (modulo 2^AW; wraps from all-ones to 0). For writes, MEM_WD = lane i and MEM_WE=1. After beat VLEN-1, go to DRAIN.
- Read lane capture: lane i is written into the lane buffer at the end of the cycle after beat i. The last lane is captured in DRAIN.
- DRAIN: no grants and no RAM access. Next state is IDLE. V_DONE is registered and asserted in the following cycle, for both reads and writes.
- V_RD holds its value from V_DONE until the next vector read's lanes begin overwriting it.
- Requests arriving during BURST/DRAIN wait; they are resolved by round-robin on return to IDLE.
- Reset mid-operation: state→IDLE and all outputs go to 0 immediately (MEM_WE deasserts asynchronously). The lane buffer is cleared and no V_DONE is produced.
- Reset values: S_GNT, S_RVALID, V_GNT, V_DONE, MEM_WE=0; MEM_A, MEM_WD, V_RD=0; S_RD follows MEM_RD.

## Timing
- Scalar: grant and access happen in the same cycle when the arbiter is free; read latency is 1 cycle after S_GNT.
- Vector: grant at cycle t, beats at t..t+VLEN-1, DRAIN at t+VLEN, V_DONE at t+VLEN+1. The RAM is free for grants again at t+VLEN+1.
- Maximum scalar wait behind a burst is VLEN+1 cycles.

## Configuration
- MEM_ARB_STALL_CNT_EN defined:
  - STALL_S counts cycles with S_REQ=1 and S_GNT=0.
  - STALL_V counts cycles with V_REQ=1 and V_GNT=0.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package mem_arb_pkg: FSM state enum (IDLE, BURST, DRAIN) and default AW/DW/VLEN constants.
- Sub-module mem_arb_vbuf: VLEN×DW lane register with per-lane write enable and asynchronous clear. Used for both the latched V_WD and the read lane buffer.

## Test plan
- Scalar only, write 32'hDEAD_BEEF @10 then read @10 → S_GNT same cycle each time; S_RVALID next cycle with S_RD=32'hDEAD_BEEF.
- Vector write base 100, V_WD lanes {4,3,2,1} (lane 0 = 1), then vector read base 100 → MEM_A 100..103 with MEM_WE=1; V_DONE at grant+5; V_RD = {4,3,2,1}.
- Simultaneous S_REQ/V_REQ out of reset → scalar granted first; vector granted the next cycle; a second tie then grants scalar, alternating.
- Scalar request during a burst granted at t → S_GNT at t+VLEN+1 = t+5; with the macro defined, STALL_S increments once per waiting cycle.
- Vector base 32'hFFFF_FFFE → beats at FFFF_FFFE, FFFF_FFFF, 0, 1.
- RST low at beat 2 of a write burst → MEM_WE=0 immediately; no V_DONE; state IDLE; LAST_V=1 after release.
